// File: rtl/qspi_fill_arbiter_if.sv
// ---------------------------------------------------------------------------
// qspi_fill_arbiter_if
//   Bundles the two requester line-fill handshakes and the flash line reader
//   handshake seen by qspi_fill_arbiter. All signals are in the HCLK domain.
//
//   Requester side : req0/addr0/done0, req1/addr1/done1, shared line_o
//   Status         : busy
//   Reader side    : fr_rd/fr_addr (to reader), fr_done/fr_line (from reader)
//
//   slave  : the arbiter's view (drives done*, line_o, busy, fr_rd, fr_addr)
//   master : the environment's view (requesters plus flash reader)
// ---------------------------------------------------------------------------
interface qspi_fill_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int LINE_W = 128
) ();
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              done0;
    logic              done1;
    logic [LINE_W-1:0] line_o;
    logic              busy;
    logic              fr_rd;
    logic [ADDR_W-1:0] fr_addr;
    logic              fr_done;
    logic [LINE_W-1:0] fr_line;

    modport slave (
        input  req0, addr0, req1, addr1, fr_done, fr_line,
        output done0, done1, line_o, busy, fr_rd, fr_addr
    );

    modport master (
        output req0, addr0, req1, addr1, fr_done, fr_line,
        input  done0, done1, line_o, busy, fr_rd, fr_addr
    );
endinterface

// File: rtl/qspi_fill_arbiter.sv
// ---------------------------------------------------------------------------
// qspi_fill_arbiter
//   Shares one quad-SPI flash line reader between two line-fill requesters
//   (0 = instruction cache, 1 = data cache/DMA). One pending request is
//   granted in IDLE, the reader is strobed with the line-aligned address, the
//   returned line is captured and handed back with a done pulse. Requests for
//   the same line from both sides in the same IDLE cycle share one fill.
//
//   Ports:
//     HCLK     clock, rising edge
//     HRESETn  asynchronous active-low reset
//     bus      qspi_fill_arbiter_if.slave
//                req0/addr0, req1/addr1  level requests, address sampled at grant
//                done0/done1             1-cycle completion pulses
//                line_o                  registered fill data
//                busy                    high outside IDLE
//                fr_rd/fr_addr           read strobe and aligned address to reader
//                fr_done/fr_line         reader completion and line data
// ---------------------------------------------------------------------------
module qspi_fill_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int LINE_W     = 128,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    qspi_fill_arbiter_if.slave   bus
);

    localparam int OFS = $clog2(LINE_W / 8);
    localparam int LA_W = ADDR_W - OFS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;

    logic              gnt0_q, gnt1_q;
    logic              merged_q;
    logic              last_gnt_q;
    logic [ADDR_W-1:0] fr_addr_q;
    logic [LINE_W-1:0] line_q;

    logic [LA_W-1:0]   line_addr0, line_addr1;
    logic              merge;
    logic              pick1;

    logic              fr_rd_c, done0_c, done1_c, busy_c;

    // Arbitration: a lone request wins; on a tie either fixed priority to 0
    // or the requester that was not served last. Equal lines merge.
    always_comb begin
        line_addr0 = bus.addr0[ADDR_W-1:OFS];
        line_addr1 = bus.addr1[ADDR_W-1:OFS];
        merge      = bus.req0 & bus.req1 & (line_addr0 == line_addr1);
        if (FIXED_PRIO != 0) begin
            pick1 = bus.req1 & ~bus.req0;
        end else begin
            pick1 = bus.req1 & (~bus.req0 | ~last_gnt_q);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fr_rd_c = 1'b0;
        done0_c = 1'b0;
        done1_c = 1'b0;
        busy_c  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (bus.req0 | bus.req1) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fr_rd_c = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.fr_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                done0_c = gnt0_q;
                done1_c = gnt1_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant/address latch, line capture and round-robin history.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            merged_q   <= 1'b0;
            last_gnt_q <= 1'b1;
            fr_addr_q  <= '0;
            line_q     <= '0;
        end else begin
            if (state_q == ST_IDLE && (bus.req0 | bus.req1)) begin
                gnt0_q    <= merge | ~pick1;
                gnt1_q    <= merge | pick1;
                merged_q  <= merge;
                fr_addr_q <= {(pick1 ? line_addr1 : line_addr0), {OFS{1'b0}}};
            end
            // fr_done outside WAIT is deliberately ignored.
            if (state_q == ST_WAIT && bus.fr_done) begin
                line_q <= bus.fr_line;
            end
            // A merged fill served both sides, so the tie history is kept.
            if (state_q == ST_RESP && !merged_q) begin
                last_gnt_q <= gnt1_q;
            end
        end
    end

    assign bus.fr_rd   = fr_rd_c;
    assign bus.fr_addr = fr_addr_q;
    assign bus.done0   = done0_c;
    assign bus.done1   = done1_c;
    assign bus.busy    = busy_c;
    assign bus.line_o  = line_q;

endmodule
